// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window sequencer.
// Build option: CONV_SEQ_ZERO_PAD_EN selects zero-padded same-size output (PAD=1);
// left undefined, the sequencer produces valid-only convolution (PAD=0).
package conv_pkg;

  localparam int K      = 3;
  localparam int KK     = K * K;
  localparam int DATA_W = 8;
  localparam int PSUM_W = 16;

`ifdef CONV_SEQ_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  typedef logic signed [DATA_W-1:0] pixel_t;
  typedef logic signed [DATA_W-1:0] weight_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  // Kernel row of a row-major tap index (t / 3)
  function automatic logic [1:0] tap_row(input logic [3:0] t);
    logic [1:0] r;
    case (t)
      4'd0, 4'd1, 4'd2: r = 2'd0;
      4'd3, 4'd4, 4'd5: r = 2'd1;
      default:          r = 2'd2;
    endcase
    return r;
  endfunction

  // Kernel column of a row-major tap index (t % 3)
  function automatic logic [1:0] tap_col(input logic [3:0] t);
    logic [1:0] c;
    case (t)
      4'd0, 4'd3, 4'd6: c = 2'd0;
      4'd1, 4'd4, 4'd7: c = 2'd1;
      default:          c = 2'd2;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/conv_img_buffer.sv
// Image register array: one write port fed by the load stream and a
// combinational read of the 2x2 pixel group anchored at (base_row, base_col).
// Coordinates outside the image read back as zero (border fill when padding).
module conv_img_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  pixel_t            wdata,
  input  logic signed [5:0] base_row,
  input  logic signed [5:0] base_col,
  output pixel_t            pix_1,
  output pixel_t            pix_2,
  output pixel_t            pix_3,
  output pixel_t            pix_4
);

  localparam int NPIX = IMG_W * IMG_H;

  pixel_t mem [NPIX];
  pixel_t pix [4];
  int     rr  [4];
  int     cc  [4];
  int     lin [4];

  // Load-stream write; contents survive reset and are overwritten by the next load
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Fetch the four neighbours (dr,dc) in {0,1}x{0,1} with zero-fill out of range
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      rr[n]  = int'(base_row) + (n / 2);
      cc[n]  = int'(base_col) + (n % 2);
      lin[n] = rr[n] * IMG_W + cc[n];
      pix[n] = '0;
      if (rr[n] >= 0 && rr[n] < IMG_H && cc[n] >= 0 && cc[n] < IMG_W)
        pix[n] = mem[lin[n][AW-1:0]];
    end
  end

  assign pix_1 = pix[0];
  assign pix_2 = pix[1];
  assign pix_3 = pix[2];
  assign pix_4 = pix[3];

endmodule

// File: rtl/conv_window_sequencer.sv
// Loads a 3x3 kernel and an image, then walks the output in 2x2 tiles,
// presenting one kernel tap per cycle to four MAC lanes.
// Build option: CONV_SEQ_ZERO_PAD_EN (see conv_pkg) selects padded output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | accepting 9 kernel taps then IMG_W*IMG_H pixels
// S_CLEAR | clear MAC accumulators for the next tile
// S_FEED  | 9 cycles, one kernel tap per cycle to all four lanes
// S_DRAIN | engine outputs hold the finished tile
// S_DONE  | one-cycle end-of-frame pulse
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  pixel_t     in_data,
  output logic       in_ready,
  output weight_t    w_out,
  output pixel_t     x_out_1,
  output pixel_t     x_out_2,
  output pixel_t     x_out_3,
  output pixel_t     x_out_4,
  output logic       mac_clear,
  output logic       mac_valid,
  output logic       tile_done,
  output logic [3:0] tile_row,
  output logic [3:0] tile_col,
  output logic       busy,
  output logic       frame_done
);

  localparam int NPIX     = IMG_W * IMG_H;
  localparam int NBEAT    = KK + NPIX;
  localparam int LCW      = $clog2(NBEAT + 1);
  localparam int AW       = $clog2(NPIX);
  localparam int LAST_ROW = IMG_H - 4 + 2 * PAD;
  localparam int LAST_COL = IMG_W - 4 + 2 * PAD;

  state_e            state, state_nxt;
  logic [LCW-1:0]    load_cnt;
  logic [3:0]        tap_left;
  logic [3:0]        tap;
  weight_t           kernel [KK];
  logic              beat;
  logic              last_tile;
  logic signed [5:0] base_row, base_col;
  pixel_t            pix_1, pix_2, pix_3, pix_4;

  assign beat      = (state == S_LOAD) && in_valid;
  assign tap       = 4'(KK - 1) - tap_left;
  assign last_tile = (tile_row == 4'(LAST_ROW)) && (tile_col == 4'(LAST_COL));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    mac_clear  = 1'b0;
    mac_valid  = 1'b0;
    tile_done  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && load_cnt == LCW'(NBEAT - 1)) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        mac_clear = 1'b1;
        state_nxt = S_FEED;
      end
      S_FEED: begin
        mac_valid = 1'b1;
        if (tap_left == 4'd0) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        tile_done = 1'b1;
        state_nxt = last_tile ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load counter, tap down-counter and tile walk
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt <= '0;
      tap_left <= '0;
      tile_row <= '0;
      tile_col <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            load_cnt <= '0;
            tile_row <= '0;
            tile_col <= '0;
          end
        end
        S_LOAD:  if (in_valid) load_cnt <= load_cnt + 1'b1;
        S_CLEAR: tap_left <= 4'(KK - 1);
        S_FEED:  if (tap_left != 4'd0) tap_left <= tap_left - 1'b1;
        S_DRAIN: begin
          if (!last_tile) begin
            if (tile_col == 4'(LAST_COL)) begin
              tile_col <= '0;
              tile_row <= tile_row + 4'd2;
            end else begin
              tile_col <= tile_col + 4'd2;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Kernel taps occupy the first KK beats of the load stream
  always_ff @(posedge clk) begin
    if (beat && load_cnt < LCW'(KK)) kernel[load_cnt[3:0]] <= in_data;
  end

  assign base_row = 6'(tile_row) + 6'(tap_row(tap)) - 6'(PAD);
  assign base_col = 6'(tile_col) + 6'(tap_col(tap)) - 6'(PAD);

  conv_img_buffer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW)
  ) u_img (
    .clk      (clk),
    .we       (beat && load_cnt >= LCW'(KK)),
    .waddr    (AW'(load_cnt - LCW'(KK))),
    .wdata    (in_data),
    .base_row (base_row),
    .base_col (base_col),
    .pix_1    (pix_1),
    .pix_2    (pix_2),
    .pix_3    (pix_3),
    .pix_4    (pix_4)
  );

  assign w_out   = mac_valid ? kernel[tap] : '0;
  assign x_out_1 = mac_valid ? pix_1 : '0;
  assign x_out_2 = mac_valid ? pix_2 : '0;
  assign x_out_3 = mac_valid ? pix_3 : '0;
  assign x_out_4 = mac_valid ? pix_4 : '0;

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels; SHALL be even, 4..16.
REQ-002 Parameter IMG_H, default 8, image height in pixels; SHALL be even, 4..16.
REQ-003 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begin frame; sampled only in IDLE.
REQ-006 in_valid  in  1  load-stream beat valid.
REQ-007 in_data  in  8 signed  load-stream beat: 9 kernel taps then IMG_W*IMG_H pixels, both row-major.
REQ-008 in_ready  out  1  load-stream ready.
REQ-009 w_out  out  8 signed  current kernel tap, fanned out to all four MAC weight inputs.
REQ-010 x_out_1..x_out_4  out  8 signed each  pixels for output (r,c), (r,c+1), (r+1,c), (r+1,c+1) of current tile.
REQ-011 mac_clear  out  1  accumulator clear to the conv engine.
REQ-012 mac_valid  out  1  accumulate strobe to the conv engine.
REQ-013 tile_done  out  1  engine outputs hold a finished 2x2 tile.
REQ-014 tile_row, tile_col  out  4 each  output coordinates of the top-left pixel of the finished tile.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frame_done  out  1  one-cycle pulse at end of frame.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, CLEAR, FEED, DRAIN, DONE.
REQ-018 IDLE: in_ready=0; start=1 -> LOAD next cycle; start in any other state SHALL be ignored.
REQ-019 LOAD: in_ready=1; each in_valid&in_ready beat stored at next slot; in_valid low stalls without loss; after beat 9+IMG_W*IMG_H -> CLEAR.
REQ-020 in_valid outside LOAD SHALL be ignored and never written.
REQ-021 CLEAR: mac_clear=1, mac_valid=0 for exactly one cycle -> FEED.
REQ-022 FEED: exactly 9 cycles, tap t=0..8, kr=t/3, kc=t%3; mac_valid=1; w_out=kernel[t]; x_out_n = img[r+dr+kr-P][c+dc+kc-P], (dr,dc) per REQ-010.
REQ-023 Out-of-range image coordinates SHALL yield x_out=0.
REQ-024 DRAIN: one cycle after last FEED cycle; tile_done=1, tile_row/tile_col valid; last tile -> DONE, else next tile -> CLEAR.
REQ-025 Tile order: tile_col advances by 2 first, then tile_row by 2; both start at 0.
REQ-026 Each tile SHALL take exactly 11 cycles (CLEAR+9 FEED+DRAIN).
REQ-027 DONE: frame_done=1 one cycle -> IDLE; kernel/image buffers retained but SHALL be reloaded on next start.
REQ-028 Outside their states w_out, x_out_n, mac_clear, mac_valid, tile_done SHALL be 0.
REQ-029 Output count per frame: ((IMG_W-2*(1-P))/2)*((IMG_H-2*(1-P))/2) tiles.

Reset
REQ-030 reset=1 SHALL force IDLE next edge, any state, including mid-LOAD or mid-FEED.
REQ-031 Reset values: all outputs 0, load counter 0, tap counter 0, tile_row/tile_col 0; buffer contents need not be cleared.

Configuration
REQ-032 Macro CONV_SEQ_ZERO_PAD_EN defined: P=1, same-size output IMG_W x IMG_H, border taps zero-filled per REQ-023.
REQ-033 Macro undefined: P=0, valid convolution, output (IMG_W-2) x (IMG_H-2); out-of-range taps never generated.

Structure
REQ-034 Shared package conv_pkg SHALL hold the state enum, K=3, KK=9, DATA_W=8, PSUM_W=16 and pixel/weight typedefs.
REQ-035 Sub-module conv_img_buffer SHALL hold the image register array, write port from LOAD, combinational 4-pixel read with zero-fill.

Verification
REQ-036 No pad, 8x8, kernel all 1, image all 1 -> 9 tile_done pulses, engine out_1..4=9 each; frame_done 99 cycles after first CLEAR cycle.
REQ-037 No pad, identity kernel (tap 4=1, else 0), pixel=row*8+col -> tile (0,0) at t=4: x_out_1..4=9,10,17,18; engine outputs 9,10,17,18.
REQ-038 CONV_SEQ_ZERO_PAD_EN, kernel all 1, image all 1 -> 16 tile_done pulses; tile (0,0) outputs 4,6,6,9.
REQ-039 in_valid toggled every other cycle in LOAD -> exactly 73 beats accepted, results identical to REQ-036.
REQ-040 reset during FEED of tile 3 -> next cycle busy=0, all outputs 0; following start reloads and completes a correct frame.
REQ-041 start pulsed during FEED -> no effect; single frame_done.
